// File: rtl/axis_pkg.sv
// Shared types and helpers for the axis packetizer and related stream blocks.
`timescale 1ns/1ps
package axis_pkg;

  // Packetizer sequencing: header, then payload, then optional checksum trailer.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    TRAILER = 2'd2
  } state_t;

  // Widest header the encoder produces; callers truncate to their word width.
  localparam int HDR_W = 32;

  // Packet length: everything available, capped at the maximum packet size.
  function automatic int min_len(input int avail, input int max_len);
    return (avail < max_len) ? avail : max_len;
  endfunction

  // Header word is the payload length, zero-extended.
  function automatic logic [HDR_W-1:0] hdr_encode(input int len);
    return HDR_W'(len);
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Registered stream output stage: loads a new word whenever the slot is
// empty or being consumed, and holds data/last/valid stable under backpressure.
`timescale 1ns/1ps
module axis_out_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  input  logic                  oready,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  olast,
  output logic                  ovalid,
  output logic                  load_ok
);

  assign load_ok = !ovalid || oready;

  // Output slot: load on request, drop valid once consumed, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      odata  <= '0;
      olast  <= 1'b0;
      ovalid <= 1'b0;
    end else if (load) begin
      odata  <= ld_data;
      olast  <= ld_last;
      ovalid <= 1'b1;
    end else if (oready) begin
      ovalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_packetizer.sv
// Drains an upstream FIFO into length-prefixed packets of up to MAX_LEN words.
// Full packets go out as soon as MAX_LEN words are available; a partial packet
// is flushed once data has waited TIMEOUT cycles.
// Build option: define AXIS_PACKETIZER_CHECKSUM_EN to append an XOR trailer
// word (header ^ payload) after each packet; olast then moves to the trailer.
`timescale 1ns/1ps
module axis_packetizer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_LEN    = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] size,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  ivalid,
  output logic                  iready,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  ovalid,
  output logic                  olast,
  input  logic                  oready
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam logic [AW1-1:0] MAX_LEN_V = AW1'(MAX_LEN);
  localparam logic [AW1-1:0] ONE_V     = AW1'(1);
  localparam logic [TW-1:0]  TIMEOUT_V = TW'(TIMEOUT);

  state_t                state;
  logic [TW-1:0]         timer;
  logic [AW1-1:0]        remaining;
  logic [AW1-1:0]        avail;
  logic [AW1-1:0]        len;
  logic [DATA_WIDTH-1:0] hdr;
  logic                  load_ok;
  logic                  start;
  logic                  take;
  logic                  load;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_last;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
`endif

  // The FIFO output register holds one word beyond the reported occupancy.
  assign avail = {1'b0, size} + AW1'(ivalid);
  assign len   = AW1'(min_len(int'(avail), MAX_LEN));
  assign hdr   = DATA_WIDTH'(hdr_encode(int'(len)));

  assign start = (state == IDLE) && load_ok &&
                 ((avail >= MAX_LEN_V) || ((avail != '0) && (timer == TIMEOUT_V)));

  // Gated by reset so no upstream word is consumed while the packet is abandoned.
  assign iready = !reset && (state == PAYLOAD) && load_ok && (remaining != '0);
  assign take   = ivalid && iready;

  // Select what the output slot loads this cycle: header, payload or trailer.
  always_comb begin
    load    = 1'b0;
    ld_data = idata;
    ld_last = 1'b0;
    if (start) begin
      load    = 1'b1;
      ld_data = hdr;
    end else if (take) begin
      load    = 1'b1;
      ld_data = idata;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
      ld_last = 1'b0;
`else
      ld_last = (remaining == ONE_V);
`endif
    end
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
    else if ((state == TRAILER) && load_ok) begin
      load    = 1'b1;
      ld_data = csum;
      ld_last = 1'b1;
    end
`endif
  end

  // Packet sequencer: idle timer, payload word count and checksum accumulator.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      remaining <= '0;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= PAYLOAD;
            remaining <= len;
            timer     <= '0;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
            csum      <= hdr;
`endif
          end else if (avail == '0) begin
            timer <= '0;
          end else if (timer != TIMEOUT_V) begin
            timer <= timer + 1'b1;
          end
        end
        PAYLOAD: begin
          if (take) begin
            remaining <= remaining - 1'b1;
`ifdef AXIS_PACKETIZER_CHECKSUM_EN
            csum      <= csum ^ idata;
            if (remaining == ONE_V) state <= TRAILER;
`else
            if (remaining == ONE_V) state <= IDLE;
`endif
          end
        end
        TRAILER: begin
          if (load_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  axis_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .ld_data (ld_data),
    .ld_last (ld_last),
    .oready  (oready),
    .odata   (odata),
    .olast   (olast),
    .ovalid  (ovalid),
    .load_ok (load_ok)
  );

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer. The upstream FIFO is modelled as a
// queue whose head sits in the output register (ivalid) and whose remaining
// depth is reported on size. ADDR_WIDTH is widened to 5 so that 20 words can
// be queued at once. Expected streams follow AXIS_PACKETIZER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_axis_packetizer;

`ifdef AXIS_PACKETIZER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic [4:0] size;
  logic [7:0] idata;
  logic       ivalid;
  logic       iready;
  logic [7:0] odata;
  logic       ovalid;
  logic       olast;
  logic       oready;

  axis_packetizer #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(5),
    .MAX_LEN   (8),
    .TIMEOUT   (255)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .size   (size),
    .idata  (idata),
    .ivalid (ivalid),
    .iready (iready),
    .odata  (odata),
    .ovalid (ovalid),
    .olast  (olast),
    .oready (oready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] src_q[$];
  logic [8:0] out_q[$];
  logic [8:0] exp_q[$];
  int         out_cyc[$];
  int         cyc = 0;
  bit         bp_en = 0;
  int         phase = 0;
  int         stall_viol = 0;
  bit         have_prev = 0;
  logic       prev_v, prev_r, prev_l;
  logic [7:0] prev_d;

  task automatic drive_fifo();
    ivalid = (fifo_q.size() > 0);
    idata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    size   = (fifo_q.size() > 0) ? 5'(fifo_q.size() - 1) : 5'd0;
  endtask

  // One clock: sample at the falling edge, update the upstream model just after the rising edge.
  task automatic cycle();
    logic       fire;
    logic [7:0] tmp;
    @(negedge clock);
    fire = ivalid && iready;
    if (ovalid && oready) begin
      out_q.push_back({olast, odata});
      out_cyc.push_back(cyc);
    end
    if (have_prev && prev_v && !prev_r &&
        (ovalid !== 1'b1 || odata !== prev_d || olast !== prev_l))
      stall_viol++;
    prev_v = ovalid; prev_r = oready; prev_d = odata; prev_l = olast;
    have_prev = 1;
    @(posedge clock);
    #1;
    cyc++;
    if (fire) tmp = fifo_q.pop_front();
    if (src_q.size() > 0) fifo_q.push_back(src_q.pop_front());
    if (bp_en) begin
      phase++;
      oready = ((phase % 4) == 0) || ((phase % 4) == 3);
    end
    drive_fifo();
  endtask

  // Expected packet of consecutive payload values starting at first.
  task automatic exp_pkt(input logic [7:0] first, input int len);
    logic [7:0] x;
    logic [7:0] w;
    x = 8'(len);
    exp_q.push_back({1'b0, x});
    for (int i = 0; i < len; i++) begin
      w = 8'(first + i);
      x = x ^ w;
      exp_q.push_back({(i == len - 1) && !CK_EN, w});
    end
    if (CK_EN) exp_q.push_back({1'b1, x});
  endtask

  task automatic clear_streams();
    out_q.delete();
    exp_q.delete();
    out_cyc.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    oready = 1'b1;
    drive_fifo();
    repeat (3) cycle();
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid: got %b expected 0", ovalid); end
    checks++; if (olast !== 1'b0) begin errors++; $display("FAIL reset_olast: got %b expected 0", olast); end
    checks++; if (odata !== 8'h00) begin errors++; $display("FAIL reset_odata: got %h expected 00", odata); end
    checks++; if (iready !== 1'b0) begin errors++; $display("FAIL reset_iready: got %b expected 0", iready); end
    reset = 1'b0;
    repeat (5) cycle();
    checks++; if (out_q.size() !== 0) begin errors++; $display("FAIL reset_idle_out: got %0d words expected 0", out_q.size()); end
    clear_streams();
  endtask

  task automatic test_full_packet();
    clear_streams();
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h10 + i));
    exp_pkt(8'h10, 8);
    repeat (40) cycle();
    checks++; if (out_q.size() !== exp_q.size()) begin errors++; $display("FAIL full_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_word%0d: got %h expected %h", i, out_q[i], exp_q[i]); end
    end
    if (out_cyc.size() > 0) begin
      checks++;
      if (out_cyc[out_cyc.size()-1] - out_cyc[0] !== out_cyc.size() - 1) begin
        errors++; $display("FAIL full_continuous: span %0d cycles for %0d words", out_cyc[out_cyc.size()-1] - out_cyc[0] + 1, out_cyc.size());
      end
    end
  endtask

  task automatic test_timeout_partial();
    int waited;
    clear_streams();
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h02); fifo_q.push_back(8'h03);
    drive_fifo();
    exp_pkt(8'h01, 3);
    waited = 0;
    while (out_q.size() == 0 && waited < 400) begin
      cycle();
      waited++;
    end
    // Timer counts 0..255 across the first 256 cycles, start fires at 255,
    // and the header is visible in the following cycle.
    checks++; if (waited !== 257) begin errors++; $display("FAIL timeout_latency: got %0d cycles expected 257", waited); end
    repeat (10) cycle();
    checks++; if (out_q.size() !== exp_q.size()) begin errors++; $display("FAIL timeout_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_word%0d: got %h expected %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    clear_streams();
    for (int i = 0; i < 20; i++) fifo_q.push_back(8'(8'h20 + i));
    drive_fifo();
    exp_pkt(8'h20, 8);
    exp_pkt(8'h28, 8);
    exp_pkt(8'h30, 4);
    repeat (340) cycle();
    checks++; if (out_q.size() !== (CK_EN ? 26 : 23)) begin errors++; $display("FAIL overflow_count: got %0d expected %0d", out_q.size(), CK_EN ? 26 : 23); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL overflow_word%0d: got %h expected %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    clear_streams();
    stall_viol = 0;
    have_prev = 0;
    phase = 0;
    oready = 1'b1;
    bp_en = 1;
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h10 + i));
    exp_pkt(8'h10, 8);
    repeat (80) cycle();
    bp_en = 0;
    oready = 1'b1;
    repeat (5) cycle();
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_viol); end
    checks++; if (out_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d: got %h expected %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    int n;
    clear_streams();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h10 + i));
    drive_fifo();
    n = 0;
    while (!(ovalid === 1'b1 && odata === 8'h12) && n < 50) begin
      cycle();
      n++;
    end
    checks++; if (n >= 50) begin errors++; $display("FAIL midrst_reach: third payload word not seen, odata %h", odata); end
    reset = 1'b1;
    cycle();
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL midrst_ovalid: got %b expected 0", ovalid); end
    checks++; if (iready !== 1'b0) begin errors++; $display("FAIL midrst_iready: got %b expected 0", iready); end
    fifo_q.delete();
    src_q.delete();
    drive_fifo();
    reset = 1'b0;
    clear_streams();
    repeat (300) cycle();
    checks++; if (out_q.size() !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d words expected 0", out_q.size()); end
  endtask

  task automatic test_checksum();
    clear_streams();
    fifo_q.push_back(8'h01); fifo_q.push_back(8'h02); fifo_q.push_back(8'h04);
    drive_fifo();
    exp_q.push_back({1'b0, 8'h03});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({!CK_EN, 8'h04});
    if (CK_EN) exp_q.push_back({1'b1, 8'h04});
    repeat (275) cycle();
    checks++; if (out_q.size() !== exp_q.size()) begin errors++; $display("FAIL cksum_count: got %0d expected %0d", out_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL cksum_word%0d: got %h expected %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    reset  = 1'b1;
    oready = 1'b1;
    ivalid = 1'b0;
    idata  = 8'h00;
    size   = 5'd0;
    test_reset();
    test_full_packet();
    test_timeout_partial();
    test_overflow();
    test_backpressure();
    test_reset_mid_packet();
    test_checksum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
